// File: rtl/dmem_unit.sv
// rtl/dmem_unit.sv - byte-addressed RV32I data memory with valid/ready request and fixed-latency response
// One request outstanding at a time; loads return after READ_LATENCY cycles, stores and errors after one.
module dmem_unit #(
  parameter int XLEN         = 32,
  parameter int MEM_SIZE     = 2048,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  input  logic [XLEN-1:0] dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
);

  localparam int AW = $clog2(MEM_SIZE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // WAIT holds for READ_LATENCY-1 cycles; the counter runs down to zero.
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

  logic [XLEN-1:0] mem [MEM_SIZE];

  logic [1:0]      state_q;
  logic [1:0]      cnt_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [1:0]      size;
  logic            out_of_range;
  logic            f3_bad;
  logic            misalign;
  logic            req_err;
  logic            accept;
  logic            do_write;
  logic [XLEN-1:0] word_rd;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] wdata_rep;
  logic [3:0]      be;
  logic            unused_dbg;

  assign idx          = req_addr_i[AW+1:2];
  assign lane         = req_addr_i[1:0];
  assign size         = req_funct3_i[1:0];
  assign out_of_range = |req_addr_i[XLEN-1:AW+2];
  assign f3_bad       = req_we_i ? (req_funct3_i[2] | (&req_funct3_i[1:0]))
                                 : ((&req_funct3_i[1:0]) | (req_funct3_i[2] & req_funct3_i[1]));
  assign misalign     = ((size == 2'd1) & lane[0]) | ((size == 2'd2) & (lane != 2'd0));
  assign req_err      = f3_bad | misalign | out_of_range;
  assign accept       = req_valid_i & req_ready_o;
  assign do_write     = rstn_i & accept & req_we_i & ~req_err;

  assign word_rd  = mem[idx];
  assign byte_sel = word_rd[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    load_ext = '0;
    case (req_funct3_i)
      3'd0:    load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'd1:    load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'd2:    load_ext = word_rd;
      3'd4:    load_ext = {{(XLEN-8){1'b0}}, byte_sel};
      3'd5:    load_ext = {{(XLEN-16){1'b0}}, half_sel};
      default: load_ext = '0;
    endcase
  end

  // Replicating the store data lets every lane take its byte from the same position.
  always_comb begin
    wdata_rep = req_wdata_i;
    be        = 4'b1111;
    case (size)
      2'd0: begin
        wdata_rep = {4{req_wdata_i[7:0]}};
        be        = 4'b0001 << lane;
      end
      2'd1: begin
        wdata_rep = {2{req_wdata_i[15:0]}};
        be        = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_rep = req_wdata_i;
        be        = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            err_q   <= req_err;
            rdata_q <= (req_we_i || req_err) ? '0 : load_ext;
            if (!req_we_i && !req_err && READ_LATENCY > 1) begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_INIT;
            end else begin
              state_q <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 2'd1;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o & err_q;

  assign dbg_data_o  = mem[dbg_addr_i[AW-1:0]];
  assign unused_dbg  = ^dbg_addr_i[XLEN-1:AW];

endmodule

// File: tb/tb_dmem_unit.sv
// tb/tb_dmem_unit.sv - randomized self-checking bench for dmem_unit against a byte-array model
module tb_dmem_unit;

  localparam int XLEN     = 32;
  localparam int MEM_SIZE = 2048;
  localparam int RL       = 3;

  logic            clk;
  logic            rstn;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic [XLEN-1:0] dbg_addr;
  logic [XLEN-1:0] dbg_data;

  dmem_unit #(.XLEN(XLEN), .MEM_SIZE(MEM_SIZE), .READ_LATENCY(RL)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .dbg_addr_i   (dbg_addr),
    .dbg_data_o   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [MEM_SIZE*4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz;
    if (addr >= MEM_SIZE*4) return 1'b1;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    sz = 1 << f3[1:0];
    return (addr % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [7:0]  b;
    logic [15:0] h;
    int          v;
    b = ref_mem[addr];
    h = {ref_mem[addr+1], ref_mem[addr]};
    case (f3)
      3'd0:    begin v = $signed(b); return v; end
      3'd1:    begin v = $signed(h); return v; end
      3'd2:    return {ref_mem[addr+3], ref_mem[addr+2], h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 1 << f3[1:0];
    for (int k = 0; k < n; k++) ref_mem[addr+k] = wdata[8*k +: 8];
  endtask

  function automatic logic [31:0] model_word(input int widx);
    return {ref_mem[4*widx+3], ref_mem[4*widx+2], ref_mem[4*widx+1], ref_mem[4*widx]};
  endfunction

  task automatic check_dbg(input string tag, input int widx, input logic [31:0] exp);
    dbg_addr = widx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Issue one request, keep the bus busy with a decoy store until the response, and score it.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got);
    logic        e;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          cyc;
    bit          seen;
    e       = model_err(we, f3, addr);
    exp_rd  = (we || e) ? 32'h0 : model_load(f3, addr);
    exp_lat = (we || e) ? 1 : RL;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check("ready_to_accept", req_ready, 1);
    @(posedge clk); #1;
    if (we && !e) model_store(f3, addr, wdata);
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = {addr[31:2], 2'b00}; req_wdata = ~wdata;
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk); cyc++;
      if (rsp_valid) seen = 1;
      else check("busy_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    got = rsp_rdata;
    check("rsp_seen", seen, 1);
    check("rsp_latency", cyc, exp_lat);
    check("rsp_err", rsp_err, e);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("ready_in_resp", req_ready, 0);
    @(negedge clk);
    check("ready_after_resp", req_ready, 1);
    check("single_pulse", rsp_valid, 0);
    if (!e) check_dbg("dbg_word", (addr >> 2) % MEM_SIZE, model_word((addr >> 2) % MEM_SIZE));
  endtask

  logic [31:0] got;
  logic [31:0] addr;
  int          pulses;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    rstn = 1'b1;

    for (int i = 0; i < 32; i++) do_req(1'b1, 3'd2, 32'h100 + 4*i, $urandom, got);

    do_req(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, got);
    do_req(1'b0, 3'd2, 32'h100, 32'h0, got);
    check("plan_lw", got, 32'hDEADBEEF);
    check_dbg("plan_dbg_sw", 32'h40, 32'hDEADBEEF);

    do_req(1'b1, 3'd0, 32'h102, 32'hAAAAAA11, got);
    do_req(1'b1, 3'd1, 32'h100, 32'h55552233, got);
    check_dbg("plan_lanes", 32'h40, 32'hDE112233);
    do_req(1'b0, 3'd0, 32'h103, 32'h0, got);
    check("plan_lb", got, 32'hFFFFFFDE);
    do_req(1'b0, 3'd4, 32'h103, 32'h0, got);
    check("plan_lbu", got, 32'h000000DE);
    do_req(1'b0, 3'd1, 32'h102, 32'h0, got);
    check("plan_lh", got, 32'hFFFFDE11);

    do_req(1'b0, 3'd2, 32'h101, 32'h0, got);
    do_req(1'b1, 3'd1, 32'h103, 32'h12345678, got);
    do_req(1'b0, 3'd3, 32'h100, 32'h0, got);
    do_req(1'b1, 3'd4, 32'h100, 32'h12345678, got);
    check_dbg("plan_err_untouched", 32'h40, 32'hDE112233);

    do_req(1'b0, 3'd2, 32'h2000, 32'h0, got);
    do_req(1'b1, 3'd2, 32'h1FFC, 32'hCAFEF00D, got);
    check_dbg("plan_top_word", 2047, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      addr = 32'h100 + $urandom_range(0, 127);
      if ($urandom_range(0, 15) == 0) addr = 32'h2000 + ($urandom_range(0, 255) << $urandom_range(0, 18));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, got);
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h104;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("midrst_valid", rsp_valid, 0);
    check("midrst_rdata", rsp_rdata, 0);
    check("midrst_err", rsp_err, 0);
    check("midrst_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    check("midrst_ready_after", req_ready, 1);
    check_dbg("midrst_mem_kept", 32'h41, model_word(32'h41));
    check_dbg("midrst_top_kept", 2047, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_unit.md
Name: dmem_unit

Overview:
- Parametrised data-memory unit for the RV32I core's MEMORY stage. It replaces the inline word array that handles only stores.
- Byte-addressed, byte-lane-correct stores: SB/SH/SW at any legal lane.
- Loads with sign/zero extension: LB/LH/LW/LBU/LHU.
- Misalignment and range checking.
- Valid/ready request, fixed-latency response with configurable read latency.
- Combinational debug read port for the testbench.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- MEM_SIZE, 2048, memory depth in 32-bit words; power of two, 16..65536.
- READ_LATENCY, 1, cycles from load acceptance to rsp_valid_o; legal 1..4.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I funct3: SB/SH/SW = 0/1/2; LB/LH/LW/LBU/LHU = 0/1/2/4/5.
- req_addr_i  in  XLEN  byte address.
- req_wdata_i  in  XLEN  store data; low bytes used for SB/SH.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  request rejected; valid only with rsp_valid_o.
- dbg_addr_i  in  XLEN  debug word index.
- dbg_data_o  out  XLEN  combinational mem[dbg_addr_i mod MEM_SIZE].

Behaviour:
- Reset (async assert, sync release):
  - req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, FSM=IDLE, latency counter=0.
  - Memory contents are NOT reset.
- Addressing:
  - Word index = req_addr_i[AW+1:2], where AW=$clog2(MEM_SIZE).
  - Lane = req_addr_i[1:0].
- FSM states IDLE, WAIT, RESP:
  - Only one request may be outstanding. req_ready_o=1 only in IDLE.
  - Accept on the rising edge where req_valid_i & req_ready_o.
  - Store or error accepted: go to RESP; rsp_valid_o=1 the next cycle (latency 1).
  - Legal load accepted: if READ_LATENCY==1 go to RESP; otherwise go to WAIT, count READ_LATENCY-1 cycles, then go to RESP.
  - RESP lasts one cycle: rsp_valid_o=1, then return to IDLE.
  - Earliest next accept is the cycle after RESP. Back-to-back throughput is one request per READ_LATENCY+1 cycles for loads and 2 cycles for stores.
- Error conditions (rsp_err_o=1, rsp_rdata_o=0, no memory write, latency 1):
  - funct3 illegal for the direction: store with funct3 ∉ {0,1,2}, or load with funct3 ∈ {3,6,7}.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Any address bit above AW+1 set (out of range).
- Stores:
  - Memory is written at the acceptance edge.
  - Byte enables: SB writes lane addr[1:0] with wdata[7:0]. SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]. SW writes all four lanes.
  - Untouched lanes keep their old value.
- Loads:
  - The word is read at the acceptance edge and held in a pipeline register until RESP.
  - Lane selection as for stores.
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
- dbg_data_o reflects a store written at edge N from just after edge N.
- req_* inputs are ignored while req_ready_o=0. No buffering; the requester must hold req_valid_i.
- Reset asserted in WAIT/RESP:
  - The pending response is dropped, with no rsp_valid_o pulse.
  - A store already written stays written.
  - req_ready_o=1 during reset and after release.

Test Plan:
- Store then load: SW 0xDEADBEEF @0x100, then LW @0x100, READ_LATENCY=1 → store rsp_valid 1 cycle after accept with err=0; load rsp_rdata=0xDEADBEEF 1 cycle after accept; dbg_data_o[0x40]=0xDEADBEEF.
- Byte lanes: after the above, SB 0x11 @0x102 and SH 0x2233 @0x100 → mem word 0xDE112233. LB @0x103 → 0xFFFFFFDE. LBU @0x103 → 0x000000DE. LH @0x102 → 0xFFFFDE11.
- Misalignment and illegal: LW @0x101, SH @0x103, load funct3=3, store funct3=4 → each gives rsp_err=1, rsp_rdata=0; dbg word 0x40 unchanged.
- Latency/handshake, READ_LATENCY=3: LW held valid for 4 cycles → req_ready_o low for 3 cycles, rsp_valid exactly 3 cycles after accept; second request accepted the cycle after RESP, never earlier.
- Range: MEM_SIZE=2048, LW @0x2000 → err=1. SW @0x1FFC then dbg_addr=2047 → written value visible.
- Reset mid-load: READ_LATENCY=4, assert rstn_i low 2 cycles after accept → no rsp_valid pulse; outputs 0 immediately; req_ready_o=1; prior memory contents intact.
